// File: rtl/percept_wrapper.sv
// Bit-serial register front end feeding a small signed perceptron.
// Frames of {start 0, addr[7:0], data[63:0], stop 1} load weights, inputs or bias; out = (sum > 0).
module percept_wrapper #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 16
) (
  input  logic clk,
  input  logic nRst,
  input  logic in,
  output logic out
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int BASE_W = (PROD_W > 32) ? PROD_W : 32;
  localparam int SUM_W  = BASE_W + $clog2(NUM_IN + 1) + 1;

  localparam logic [7:0] ADDR_WEIGHT = 8'h10;
  localparam logic [7:0] ADDR_INPUT  = 8'h11;
  localparam logic [7:0] ADDR_BIAS   = 8'h12;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    STOP
  } rx_state_e;

  rx_state_e                state_q, state_d;
  logic [5:0]               cnt_q, cnt_d;
  logic [7:0]               addr_q, addr_d;
  logic [63:0]              data_q, data_d;
  logic signed [WIDTH-1:0]  w_q [NUM_IN];
  logic signed [WIDTH-1:0]  w_d [NUM_IN];
  logic signed [WIDTH-1:0]  x_q [NUM_IN];
  logic signed [WIDTH-1:0]  x_d [NUM_IN];
  logic signed [31:0]       bias_q, bias_d;
  logic                     out_q, out_d;

  logic signed [PROD_W-1:0] prod [NUM_IN];
  logic signed [SUM_W-1:0]  sum;

  // Receiver and register-file update.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    w_d     = w_q;
    x_d     = x_q;
    bias_d  = bias_q;

    case (state_q)
      IDLE: begin
        if (!in) begin
          state_d = ADDR;
          cnt_d   = '0;
        end
      end
      ADDR: begin
        addr_d = {addr_q[6:0], in};
        if (cnt_q == 6'd7) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      DATA: begin
        data_d = {data_q[62:0], in};
        if (cnt_q == 6'd63) begin
          state_d = STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      STOP: begin
        // A low stop bit is a framing error; it is not taken as the next start bit.
        state_d = IDLE;
        if (in) begin
          case (addr_q)
            ADDR_WEIGHT: for (int i = 0; i < NUM_IN; i++) w_d[i] = data_q[WIDTH*i +: WIDTH];
            ADDR_INPUT:  for (int i = 0; i < NUM_IN; i++) x_d[i] = data_q[WIDTH*i +: WIDTH];
            ADDR_BIAS:   bias_d = data_q[31:0];
            default:     ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sum is wide enough that no combination of extreme operands can overflow.
  always_comb begin
    sum = SUM_W'(bias_q);
    for (int i = 0; i < NUM_IN; i++) begin
      prod[i] = w_q[i] * x_q[i];
      sum     = sum + SUM_W'(prod[i]);
    end
    out_d = ~sum[SUM_W-1] & (|sum);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (nRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      // NOTE: these small register arrays are architectural state and must read 0 after reset,
      // so they are cleared explicitly rather than treated as uninitialised memory.
      w_q     <= '{default: '0};
      x_q     <= '{default: '0};
      bias_q  <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      w_q     <= w_d;
      x_q     <= x_d;
      bias_q  <= bias_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_percept_wrapper.sv
// Self-checking bench for percept_wrapper: table of frames with a scoreboard of expected decisions,
// plus hand-written reset, mid-frame reset and back-to-back sequences.
module tb_percept_wrapper;

  logic clk = 1'b0;
  logic nRst;
  logic in;
  logic out;

  always #5 clk = ~clk;

  percept_wrapper #(.NUM_IN(4), .WIDTH(16)) dut (
    .clk  (clk),
    .nRst (nRst),
    .in   (in),
    .out  (out)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string name;
    logic  exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic [7:0]  addr;
    logic [63:0] data;
    logic        stop;
    logic        exp_out;
  } vec_t;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [73:0] mk_frame(input logic [7:0] a, input logic [63:0] d, input logic s);
    return {1'b0, a, d, s};
  endfunction

  // Bit held across exactly one rising edge; returns #1 after that edge.
  task automatic send_bit(input logic b);
    in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [63:0] d, input logic s);
    logic [73:0] f;
    f = mk_frame(a, d, s);
    for (int i = 73; i >= 0; i--) send_bit(f[i]);
  endtask

  // Called right after the stop-bit edge: out must still hold the old decision,
  // and the new decision must appear on the following edge.
  task automatic expect_next(input string name, input logic prev, input logic exp);
    sb_t e;
    check({name, "_pre"}, {31'b0, out}, {31'b0, prev});
    sb_q.push_back('{name, exp});
    send_bit(1'b1);
    e = sb_q.pop_front();
    check(e.name, {31'b0, out}, {31'b0, e.exp});
  endtask

  logic        prev;
  logic [73:0] f;

  initial begin
    vecs[0]  = '{"w_all_one",     8'h10, 64'h0001_0001_0001_0001, 1'b1, 1'b0};
    vecs[1]  = '{"basic_fire",    8'h11, 64'h0000_0000_0000_0002, 1'b1, 1'b1};
    vecs[2]  = '{"bias_m2_zero",  8'h12, 64'h0000_0000_FFFF_FFFE, 1'b1, 1'b0};
    vecs[3]  = '{"bias_m1_one",   8'h12, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1};
    vecs[4]  = '{"bias_zero",     8'h12, 64'h0000_0000_0000_0000, 1'b1, 1'b1};
    vecs[5]  = '{"w_min",         8'h10, 64'h8000_8000_8000_8000, 1'b1, 1'b0};
    vecs[6]  = '{"x_min_2p32",    8'h11, 64'h8000_8000_8000_8000, 1'b1, 1'b1};
    vecs[7]  = '{"x_max_neg",     8'h11, 64'h7FFF_7FFF_7FFF_7FFF, 1'b1, 1'b0};
    vecs[8]  = '{"x_min_again",   8'h11, 64'h8000_8000_8000_8000, 1'b1, 1'b1};
    vecs[9]  = '{"addr55_ign",    8'h55, 64'd256,                 1'b1, 1'b1};
    vecs[10] = '{"addrAA_ign",    8'hAA, 64'd128,                 1'b1, 1'b1};
    vecs[11] = '{"bad_stop_ign",  8'h11, 64'd0,                   1'b0, 1'b1};
    vecs[12] = '{"bias_min_hi",   8'h12, 64'hDEAD_BEEF_8000_0000, 1'b1, 1'b1};
    vecs[13] = '{"w_one_neg",     8'h10, 64'h0001_0001_0001_0001, 1'b1, 1'b0};
    vecs[14] = '{"bias_max",      8'h12, 64'h0000_0000_7FFF_FFFF, 1'b1, 1'b1};

    // Reset and idle line.
    in   = 1'b1;
    nRst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nRst = 1'b0;
    check("reset_out", {31'b0, out}, 32'd0);
    for (int c = 0; c < 500; c++) begin
      send_bit(1'b1);
      if (c % 50 == 49) check($sformatf("idle_%0d", c), {31'b0, out}, 32'd0);
    end

    // Table-driven frames.
    prev = 1'b0;
    for (int i = 0; i < 15; i++) begin
      send_frame(vecs[i].addr, vecs[i].data, vecs[i].stop);
      expect_next(vecs[i].name, prev, vecs[i].exp_out);
      prev = vecs[i].exp_out;
    end

    // Reset during the DATA phase of a bias frame; the rest of the stream is all ones.
    f = mk_frame(8'h12, 64'h00FF_FFFF_FFFF_FFFF, 1'b1);
    for (int i = 73; i >= 55; i--) send_bit(f[i]);
    nRst = 1'b1;
    send_bit(1'b1);
    nRst = 1'b0;
    check("midreset_out", {31'b0, out}, 32'd0);
    for (int i = 54; i >= 0; i--) send_bit(f[i]);
    for (int c = 0; c < 4; c++) begin
      send_bit(1'b1);
      check($sformatf("after_abort_%0d", c), {31'b0, out}, 32'd0);
    end
    prev = 1'b0;
    send_frame(8'h10, 64'h0001_0001_0001_0001, 1'b1);
    expect_next("x_cleared", prev, 1'b0);
    send_frame(8'h11, 64'h0000_0000_0000_FFFF, 1'b1);
    expect_next("bias_cleared", prev, 1'b0);
    send_frame(8'h12, 64'h0000_0000_0000_0002, 1'b1);
    expect_next("bias_two", prev, 1'b1);
    prev = 1'b1;

    // Back-to-back frames: second start bit immediately after first stop bit.
    send_frame(8'h11, 64'h0000_0000_0000_0003, 1'b1);
    f = mk_frame(8'h12, 64'h0000_0000_FFFF_FFFB, 1'b1);
    send_bit(f[73]);
    check("b2b_first", {31'b0, out}, 32'd1);
    for (int i = 72; i >= 0; i--) send_bit(f[i]);
    expect_next("b2b_second", prev, 1'b0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/percept_wrapper.md
Name: percept_wrapper

Overview:
Single-wire serial front end plus a small fixed-point perceptron. Serial frames write weight, input and bias registers. The block continuously evaluates sign(sum(w_i*x_i) + bias) and drives the decision on a single output bit. It sits between a bit-serial host link and downstream logic that consumes a binary classification.

Parameters:
NUM_IN, 4, number of perceptron inputs/weights; NUM_IN*WIDTH must be at most 64.
WIDTH, 16, signed two's-complement width of each weight and input.

Ports:
clk   input  1  system clock; all state updates on rising edge.
nRst  input  1  reset; synchronous, active-high despite the legacy name (1 = reset).
in    input  1  serial data line, one bit per clk cycle; idles high.
out   input/output: output  1  registered perceptron decision.

Behaviour:
- Reset (nRst=1 at a rising edge): receiver returns to IDLE, bit counter cleared, all weights, inputs and bias cleared to 0, out=0. A reset mid-frame abandons the frame with no register update.
- Frame format, one bit per cycle, MSB first:
  - start bit 0
  - 8-bit address
  - 64-bit data
  - stop bit 1
  - Total 74 cycles.
- Receiver FSM: IDLE -> ADDR -> DATA -> STOP -> IDLE.
  - IDLE: stays while in=1. in=0 moves to ADDR.
  - ADDR: shifts in 8 bits, then DATA.
  - DATA: shifts in 64 bits, then STOP.
  - STOP: if in=1, commit the write. If in=0 (framing error), discard the frame. Either way go to IDLE. The stop-cycle 0 is not treated as a new start bit.
  - Back-to-back frames allowed: a start bit can be in the cycle right after the stop bit.
- Commit happens on the edge that samples the stop bit. Address map:
  - 0x10: weight i = data[16i+15:16i], i=0..3.
  - 0x11: input i = data[16i+15:16i].
  - 0x12: bias = data[31:0] (32-bit signed); data[63:32] ignored.
  - Any other address: frame consumed, no state change.
- Arithmetic:
  - Products are signed WIDTH x WIDTH, 32 bits.
  - Sum = sign-extended products + sign-extended bias, at least 35 bits, so no overflow is possible.
- Decision: out <= 1 if sum > 0 (strictly), else 0.
  - out is registered from the current register contents every cycle.
  - out reflects a committed write on the edge after the commit edge. If the stop bit is sampled at edge k, out updates at edge k+1.
  - out never changes except through register contents or reset.
- Unmapped-address frames and bad-stop frames leave out unchanged.

Test Plan:
1. Reset: hold nRst=1 for 2 cycles, release -> out=0; an idle line (in=1) for 500 cycles -> out stays 0, no writes.
2. Basic fire:
   - Frame addr 0x10, data 0x0001000100010001 (all weights 1); then frame addr 0x11, data 0x0000000000000002 (x0=2).
   - Expected: sum 2 -> out=1 exactly one cycle after the second stop bit, and out=0 before it.
3. Bias boundary, continuing from scenario 2:
   - Frame addr 0x12, data 0x00000000FFFFFFFE (bias -2) -> sum 0 -> out=0.
   - Bias 0x00000000FFFFFFFF (-1) -> sum 1 -> out=1.
4. Width/sign extremes:
   - Weights 0x8000800080008000 and inputs 0x8000800080008000 with bias 0 -> sum 2^32 -> out=1, no overflow.
   - Then inputs 0x7FFF7FFF7FFF7FFF -> sum -4*32767*32768 -> out=0.
5. Ignored frames, each with state previously giving out=1:
   - Addr 0x55, data 256 -> out stays 1.
   - Addr 0xAA, data 128 -> out stays 1.
   - Valid addr 0x11, data 0 but stop bit 0 -> no update, out stays 1.
6. Reset mid-frame: assert nRst during the DATA phase of an addr 0x12 frame -> out=0, registers 0; the remainder of the aborted bitstream produces no commit unless it forms a complete valid frame.
